dice_display: RTL

DICE_DISPLAY -- requirements
Module: dice_display

---
 rtl/dice_pkg.sv | 18 +
 rtl/dice_pattern.sv | 9 +
 rtl/dice_display.sv | 105 ++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// dice_pkg: shared FSM encoding, LFSR constants, pip patterns and die step helper
package dice_pkg;
  typedef enum logic [1:0] {IDLE, ROLL, SETTLE, SHOW} state_t;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [8:0] PAT_0 = 9'b000_000_000;
  localparam logic [8:0] PAT_1 = 9'b000_010_000;
  localparam logic [8:0] PAT_2 = 9'b100_000_001;
  localparam logic [8:0] PAT_3 = 9'b100_010_001;
  localparam logic [8:0] PAT_4 = 9'b101_000_101;
  localparam logic [8:0] PAT_5 = 9'b101_010_101;
  localparam logic [8:0] PAT_6 = 9'b101_101_101;
  localparam logic [8:0] PAT_7 = 9'b111_101_111;
  localparam logic [7:0][8:0] PATTERNS = {PAT_7, PAT_6, PAT_5, PAT_4, PAT_3, PAT_2, PAT_1, PAT_0};
  function automatic logic [2:0] die_next(input logic [2:0] v, input logic [2:0] r);
    return (r != 3'd0 && r != 3'd7) ? r : (v == 3'd6 || v == 3'd0) ? 3'd1 : v + 3'd1;
  endfunction
endpackage

// File: rtl/dice_pattern.sv
// dice_pattern: maps a die value to its 3x3 pip LED pattern
module dice_pattern
  import dice_pkg::*;
(
  input  logic [2:0] value,
  output logic [8:0] pattern
);
  assign pattern = PATTERNS[value];
endmodule

// File: rtl/dice_display.sv
// dice_display: multi-die roller with settle FSM and multiplexed pip display
module dice_display
  import dice_pkg::*;
#(
  parameter int N_DICE       = 2,
  parameter int SCAN_DIV     = 1000,
  parameter int TICK_DIV     = 50000,
  parameter int SETTLE_STEPS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  roll_i,
  input  logic                  blank_i,
  output logic [3*N_DICE-1:0]   value_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic [8:0]            leds_o,
  output logic [N_DICE-1:0]     die_sel_o
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = N_DICE > 1 ? $clog2(N_DICE) : 1;
  localparam int CW = $clog2(SETTLE_STEPS + 1);
  state_t state;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] slot;
  logic [IW-1:0] idx;
  logic [CW-1:0] step;
  logic [15:0] lfsr;
  logic tick;
  logic [3*N_DICE-1:0] rolled;
  logic [2:0] cur;
  logic [8:0] pat;
  assign tick = tick_cnt == TW'(TICK_DIV - 1);
  assign cur = value_o[3*idx +: 3];
  always_comb begin
    rolled = value_o;
    for (int k = 0; k < N_DICE; k++) rolled[3*k +: 3] = die_next(value_o[3*k +: 3], lfsr[3*k +: 3]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      lfsr <= LFSR_SEED;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      value_o <= '0;
      step <= '0;
      valid_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (roll_i) begin
          state <= ROLL;
          busy_o <= 1'b1;
          value_o <= {N_DICE{3'd1}};
        end
        ROLL: begin
          if (tick) value_o <= rolled;
          if (!roll_i) begin
            state <= SETTLE;
            step <= '0;
          end
        end
        SETTLE: begin
          if (tick) value_o <= rolled;
          if (roll_i) state <= ROLL;
          else if (tick) begin
            step <= step + 1'b1;
            if (step + 1'b1 == CW'(SETTLE_STEPS)) begin
              state <= SHOW;
              busy_o <= 1'b0;
              valid_o <= 1'b1;
            end
          end
        end
        SHOW: if (roll_i) begin
          state <= ROLL;
          busy_o <= 1'b1;
          valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  dice_pattern u_pattern (.value(cur), .pattern(pat));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      idx <= '0;
      die_sel_o <= N_DICE'(1);
      leds_o <= '0;
    end else begin
      slot <= slot == SW'(SCAN_DIV - 1) ? '0 : slot + 1'b1;
      if (slot == SW'(SCAN_DIV - 1)) idx <= idx == IW'(N_DICE - 1) ? '0 : idx + 1'b1;
      die_sel_o <= N_DICE'(1) << idx;
      leds_o <= blank_i ? 9'h0 : pat;
    end
  end
endmodule
